riscv_slave_initiator: RTL and testbench
========================================

# riscv_slave_initiator

Bus initiator for the single-port RISC-V slave memory interface (address, write enable, byte strobes, write data, synchronous read data). It accepts burst commands on a valid/ready request channel, sequences them beat-by-beat onto the slave port, and returns read data or a write completion on a valid/ready response channel. It sits between test/DMA logic and a slave instance and is the only driver of that slave's inputs.

## Interface
- abits, 4, slave address width; also the burst-length field width
- log2_dbytes, 3, log2 of data-bus bytes; dbytes = 2**log2_dbytes, dbits = 8*dbytes
- clk  in  1  rising-edge clock
- nrst  in  1  asynchronous, active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  abits  start address
- req_len  in  abits  beats minus one (0 = single beat)
- req_wdata  in  dbits  write data of beat 0
- req_wstrb  in  dbytes  byte strobes, same for every beat
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when high with resp_valid
- resp_rdata  out  dbits  read data; 0 for write completion
- resp_addr  out  abits  address of the beat being reported
- resp_last  out  1  final response of the burst
- m_addr  out  abits  slave address
- m_w_enable  out  1  slave write enable
- m_wstrb  out  dbytes  slave byte strobes
- m_wdata  out  dbits  slave write data
- m_rdata  in  dbits  slave read data, valid one cycle after m_addr is presented

## Operation
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_CAP, RD_RESP.
- IDLE: req_ready=1; on req_valid&req_ready latch addr, len, write, wdata, wstrb; clear beat counter; go to WR if req_write else RD_ADDR. req_ready=0 in every other state.
- WR: m_w_enable=1 for exactly one cycle per beat. Beat k drives m_addr = (req_addr+k) mod 2**abits and m_wdata = (req_wdata+k) mod 2**dbits. m_wstrb = latched strobes, passed unchanged. The slave commits a write only when all strobe bits are set; partial-strobe beats are still issued and counted. After beat len, go to WR_RESP.
- WR_RESP: one response with resp_valid=1, resp_last=1, resp_rdata=0, resp_addr=address of the last beat. Hold until resp_ready, then go to IDLE.
- RD_ADDR: drive m_addr for the current beat, with m_w_enable=0. Go to RD_CAP.
- RD_CAP: m_addr held; register m_rdata into resp_rdata and the address into resp_addr. Go to RD_RESP.
- RD_RESP: resp_valid=1, resp_last=(beat==len). On resp_ready, increment the address with wrap and the beat counter, then go to RD_ADDR, or to IDLE if last. All outputs are held stable while resp_ready is low.
- Address arithmetic wraps modulo 2**abits. Write-data increment wraps modulo 2**dbits, carry discarded.
- m_w_enable is 0 in every state except WR.

## Timing
- Reset (async assert, sync release): state=IDLE; req_ready=1 after reset; resp_valid=0, resp_last=0, resp_rdata=0, resp_addr=0, m_addr=0, m_w_enable=0, m_wstrb=0, m_wdata=0.
- Reset mid-burst aborts the burst immediately. m_w_enable drops asynchronously and no response is produced.
- Write burst: handshake at edge 0; beats on cycles 1..len+1; resp_valid rises in cycle len+2.
- Read beat: address cycle, capture cycle, then response. The first resp_valid appears 3 cycles after the handshake. Each beat takes at least 3 cycles, plus any cycles resp_ready is low.
- A response is presented until it is accepted; none are dropped or duplicated. Back-to-back commands: req_ready returns high in the cycle after the final response handshake.

## Test plan
- Single write/read: write addr 0x3, len 0, wdata 0x0123456789ABCDEF, wstrb 0xFF -> one write response with resp_last=1. Read addr 0x3 -> resp_rdata 0x0123456789ABCDEF, resp_addr 0x3, resp_last=1.
- Wrapping burst: write addr 0xE, len 3, wdata 0x10 -> m_addr 0xE,0xF,0x0,0x1 with m_wdata 0x10,0x11,0x12,0x13, m_w_enable high for 4 consecutive cycles. Read-back burst -> four responses in that order, resp_last only on the 4th.
- Backpressure: read len 1 with resp_ready low for 5 cycles on the first beat -> resp_valid, resp_rdata and resp_addr stable throughout; req_ready=0; the second beat starts only after the handshake.
- Partial strobe: write addr 0x5, wstrb 0x0F, data 0xAA.. over existing 0x55.. -> write response issued; read of 0x5 returns 0x55.. unchanged.
- Reset mid-burst: assert nrst during beat 2 of a len 5 write -> m_w_enable=0 immediately; no resp_valid; after release req_ready=1 and reads show only beats 0-1 written.
- Request while busy: hold req_valid during a read burst -> req_ready stays 0 until the burst's final handshake, then the pending command is accepted.

Source files
------------

// File: rtl/riscv_slave_initiator.sv
// rtl/riscv_slave_initiator.sv - burst initiator driving a single-port RISC-V slave memory
module riscv_slave_initiator #(
    parameter int abits       = 4,
    parameter int log2_dbytes = 3,
    localparam int dbytes     = 2 ** log2_dbytes,
    localparam int dbits      = 8 * dbytes
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [abits-1:0]  req_addr,
    input  logic [abits-1:0]  req_len,
    input  logic [dbits-1:0]  req_wdata,
    input  logic [dbytes-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [dbits-1:0]  resp_rdata,
    output logic [abits-1:0]  resp_addr,
    output logic              resp_last,
    output logic [abits-1:0]  m_addr,
    output logic              m_w_enable,
    output logic [dbytes-1:0] m_wstrb,
    output logic [dbits-1:0]  m_wdata,
    input  logic [dbits-1:0]  m_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_CAP,
        RD_RESP
    } state_t;

    state_t            state, state_d;
    logic [abits-1:0]  addr_q;
    logic [abits-1:0]  len_q;
    logic [abits-1:0]  beat_q;
    logic [dbits-1:0]  wdata_q;
    logic [dbytes-1:0] wstrb_q;
    logic [dbits-1:0]  rdata_q;
    logic [abits-1:0]  raddr_q;
    logic              last_beat;

    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_last  = 1'b0;
        m_w_enable = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_write ? WR : RD_ADDR;
                end
            end
            WR: begin
                m_w_enable = 1'b1;
                if (last_beat) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                resp_valid = 1'b1;
                resp_last  = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: state_d = RD_CAP;
            RD_CAP:  state_d = RD_RESP;
            RD_RESP: begin
                resp_valid = 1'b1;
                resp_last  = last_beat;
                if (resp_ready) begin
                    state_d = last_beat ? IDLE : RD_ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat address/data advance in place so the slave port is driven straight from registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            raddr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        len_q   <= req_len;
                        beat_q  <= '0;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                    end
                end
                WR: begin
                    if (last_beat) begin
                        raddr_q <= addr_q;
                        rdata_q <= '0;
                    end else begin
                        addr_q  <= addr_q + abits'(1);
                        wdata_q <= wdata_q + dbits'(1);
                        beat_q  <= beat_q + abits'(1);
                    end
                end
                RD_CAP: begin
                    rdata_q <= m_rdata;
                    raddr_q <= addr_q;
                end
                RD_RESP: begin
                    if (resp_ready && !last_beat) begin
                        addr_q <= addr_q + abits'(1);
                        beat_q <= beat_q + abits'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_addr     = addr_q;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = wstrb_q;
    assign resp_rdata = rdata_q;
    assign resp_addr  = raddr_q;

endmodule

// File: tb/tb_riscv_slave_initiator.sv
// tb/tb_riscv_slave_initiator.sv - scoreboard bench for riscv_slave_initiator with a slave memory model
module tb_riscv_slave_initiator;

    localparam logic [63:0] FILL = 64'h5555_5555_5555_5555;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [3:0]  req_len;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic [3:0]  resp_addr;
    logic        resp_last;
    logic [3:0]  m_addr;
    logic        m_w_enable;
    logic [7:0]  m_wstrb;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;

    riscv_slave_initiator #(.abits(4), .log2_dbytes(3)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_addr(resp_addr), .resp_last(resp_last),
        .m_addr(m_addr), .m_w_enable(m_w_enable), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] a; logic [63:0] d; logic [7:0] s; } beat_t;
    typedef struct { logic [63:0] d; logic [3:0] a; logic l; } resp_t;

    beat_t       wq[$];
    resp_t       rq[$];
    logic [63:0] ref_mem [16];
    logic [63:0] mem [16];
    logic        fill;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_hs_cyc = -1;
    int          accept_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: synchronous read, write commits only with every strobe bit set.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fill) begin
            for (int i = 0; i < 16; i++) mem[i] <= FILL;
        end else begin
            m_rdata <= mem[m_addr];
            if (m_w_enable && &m_wstrb) mem[m_addr] <= m_wdata;
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            if (m_w_enable) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wr_beat", {60'd0, m_addr}, 64'hFFFF);
                end else begin
                    beat_t b;
                    b = wq.pop_front();
                    chk("m_addr", m_addr, b.a);
                    chk("m_wdata", m_wdata, b.d);
                    chk("m_wstrb", m_wstrb, b.s);
                end
            end
            if (resp_valid && resp_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_resp", {60'd0, resp_addr}, 64'hFFFF);
                end else begin
                    resp_t r;
                    r = rq.pop_front();
                    chk("resp_rdata", resp_rdata, r.d);
                    chk("resp_addr", resp_addr, r.a);
                    chk("resp_last", resp_last, r.l);
                end
                if (resp_last) last_hs_cyc = cyc;
            end
        end
    end

    // nexp: number of write beats expected to reach the slave (fewer when a reset aborts the burst).
    task automatic send(input logic w, input logic [3:0] a, input logic [3:0] l,
                        input logic [63:0] d, input logic [7:0] s, input int nexp);
        bit ok;
        int n;
        for (int k = 0; k <= int'(l); k++) begin
            logic [3:0] ak;
            ak = a + 4'(k);
            if (w) begin
                if (k < nexp) begin
                    wq.push_back('{ak, d + 64'(k), s});
                    if (&s) ref_mem[ak] = d + 64'(k);
                end
            end else begin
                rq.push_back('{ref_mem[ak], ak, (k == int'(l))});
            end
        end
        if (w && nexp == int'(l) + 1) rq.push_back('{64'd0, a + l, 1'b1});
        req_write = w; req_addr = a; req_len = l; req_wdata = d; req_wstrb = s;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = req_ready;
            if (ok) accept_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 300);
        req_valid = 1'b0;
        if (!ok) chk("req_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0 || !req_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", {63'd0, (rq.size() == 0 && wq.size() == 0 && req_ready)}, 64'd1);
    endtask

    initial begin
        nrst = 1'b0; fill = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = FILL;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1; fill = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_last", resp_last, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_addr", resp_addr, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_w_enable", m_w_enable, 0);
        chk("rst_m_wstrb", m_wstrb, 0);
        chk("rst_m_wdata", m_wdata, 0);
        @(posedge clk);
        #1;

        // Single write then read: response latency len+2 for write, 3 for read.
        send(1'b1, 4'h3, 4'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, 1);
        @(negedge clk); chk("wr_lat_c1", resp_valid, 0);
        @(negedge clk); chk("wr_lat_c2", resp_valid, 1);
        drain();
        send(1'b0, 4'h3, 4'h0, 64'd0, 8'hFF, 0);
        @(negedge clk); chk("rd_lat_c1", resp_valid, 0);
        @(negedge clk); chk("rd_lat_c2", resp_valid, 0);
        @(negedge clk); chk("rd_lat_c3", resp_valid, 1);
        drain();

        // Wrapping burst 0xE..0x1 with four consecutive write-enable cycles.
        send(1'b1, 4'hE, 4'h3, 64'h10, 8'hFF, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("wrap_wen_high", m_w_enable, 1);
        end
        @(negedge clk); chk("wrap_wen_low", m_w_enable, 0);
        drain();
        send(1'b0, 4'hE, 4'h3, 64'd0, 8'hFF, 0);
        drain();

        // Backpressure on the first beat of a two-beat read.
        resp_ready = 1'b0;
        send(1'b0, 4'hF, 4'h1, 64'd0, 8'hFF, 0);
        begin
            int n;
            n = 0;
            while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_rdata", resp_rdata, 64'h11);
            chk("bp_addr", resp_addr, 4'hF);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_m_addr", m_addr, 4'hF);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();

        // Partial strobe leaves the slave word unchanged.
        send(1'b1, 4'h5, 4'h0, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1);
        drain();
        send(1'b0, 4'h5, 4'h0, 64'd0, 8'hFF, 0);
        drain();

        // Reset during beat 2 of a six-beat write.
        send(1'b1, 4'h8, 4'h5, 64'h100, 8'hFF, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("abort_wen", m_w_enable, 0);
        repeat (3) begin @(negedge clk); chk("abort_no_resp", resp_valid, 0); end
        @(posedge clk); #1;
        nrst = 1'b1;
        #1;
        chk("abort_req_ready", req_ready, 1);
        send(1'b0, 4'h8, 4'h5, 64'd0, 8'hFF, 0);
        drain();

        // Command held while busy is accepted the cycle after the final handshake.
        send(1'b0, 4'h0, 4'h2, 64'd0, 8'hFF, 0);
        send(1'b0, 4'h3, 4'h0, 64'd0, 8'hFF, 0);
        chk("busy_accept_cycle", accept_cyc, last_hs_cyc + 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
